// File: rtl/tempsense_fmt_pkg.sv
// Shared definitions for the temperature report formatter.
//   state_e      : formatter FSM states
//   CH_*         : ASCII characters used in the record
//   IDX_*        : byte positions inside the fixed record body
//   TEMP_W/DLY_W : widths of the captured temperature and delay
package tempsense_fmt_pkg;

  localparam int unsigned TEMP_W = 13;
  localparam int unsigned DLY_W  = 12;

  typedef enum logic [1:0] {IDLE, CONV_T, CONV_D, EMIT} state_e;

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_S     = 8'h73;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_0     = 8'h30;

  localparam int unsigned IDX_SIGN   = 2;
  localparam int unsigned IDX_INT    = 3;
  localparam int unsigned IDX_DOT    = 6;
  localparam int unsigned IDX_TENTH  = 7;
  localparam int unsigned IDX_UNIT   = 8;
  localparam int unsigned IDX_DLY    = 12;
  localparam int unsigned IDX_SUFFIX = 16;
  localparam int unsigned IDX_TAIL   = 17;
  localparam int unsigned BODY_LEN   = 17;

  function automatic logic [7:0] dig_ascii(input logic [3:0] d);
    return CH_0 | {4'h0, d};
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/tempsense_fifo_formatter_bin2bcd.sv
// Sequential double-dabble binary to 4-digit BCD converter.
//   MCLK, nRESET : clock, asynchronous active-low reset
//   START        : load BIN and begin conversion
//   BIN          : binary input, BCD_WIDTH bits
//   BCD          : four BCD digits, valid while DONE is high and afterwards
//   DONE         : one-cycle pulse, BCD_WIDTH+1 cycles after START
module bin2bcd_seq #(
  parameter int unsigned BCD_WIDTH = 12
) (
  input  logic                 MCLK,
  input  logic                 nRESET,
  input  logic                 START,
  input  logic [BCD_WIDTH-1:0] BIN,
  output logic [15:0]          BCD,
  output logic                 DONE
);

  localparam int unsigned CNT_W = $clog2(BCD_WIDTH + 1);
  localparam int unsigned SH_W  = 16 + BCD_WIDTH;

  logic [SH_W-1:0]  sh_q, sh_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  always_comb begin
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    adj      = sh_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (adj[BCD_WIDTH + 4*i +: 4] >= 4'd5)
        adj[BCD_WIDTH + 4*i +: 4] = adj[BCD_WIDTH + 4*i +: 4] + 4'd3;
    end
    if (START) begin
      sh_d     = {16'h0000, BIN};
      cnt_d    = CNT_W'(BCD_WIDTH);
      active_d = 1'b1;
    end else if (active_q) begin
      sh_d  = adj << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign BCD  = sh_q[BCD_WIDTH +: 16];
  assign DONE = done_q;

endmodule

// File: rtl/tempsense_fifo_formatter.sv
// Captures temperature/delay reports, converts both to decimal and streams a
// fixed ASCII record "T=sIII.FC D=DDDDs" + EOL over a valid/ready byte port.
// Optional macro TEMPFMT_CHECKSUM_EN inserts "*HH" (XOR of bytes 0..16) before EOL.
//   MCLK, nRESET   : clock, asynchronous active-low reset
//   FIFOTEMP       : signed temperature, LSB 0.0625 degC
//   FIFODLYTIME    : unsigned startup delay, seconds
//   nFIFOSENDTEMP  : active-low report strobe (falling edge = report)
//   TXDATA/TXVALID : byte stream out, TXREADY accepts
//   BUSY           : record being converted or emitted
//   DROPPED        : sticky, a report arrived while the pending slot was full
module tempsense_fifo_formatter
  import tempsense_fmt_pkg::*;
#(
  parameter bit          EOL_CRLF  = 1'b1,
  parameter int unsigned BCD_WIDTH = 12
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic [12:0] FIFOTEMP,
  input  logic [11:0] FIFODLYTIME,
  input  logic        nFIFOSENDTEMP,
  output logic [7:0]  TXDATA,
  output logic        TXVALID,
  input  logic        TXREADY,
  output logic        BUSY,
  output logic        DROPPED
);

`ifdef TEMPFMT_CHECKSUM_EN
  localparam int unsigned CK_LEN = 3;
`else
  localparam int unsigned CK_LEN = 0;
`endif
  localparam int unsigned EOL_LEN  = EOL_CRLF ? 2 : 1;
  localparam int unsigned REC_LEN  = BODY_LEN + CK_LEN + EOL_LEN;
  localparam logic [4:0]  LAST_IDX = 5'(REC_LEN - 1);

  state_e              state_q, state_d;
  logic                prev_q, prev_d;
  logic                slot_full_q, slot_full_d;
  logic [TEMP_W-1:0]   slot_temp_q, slot_temp_d;
  logic [DLY_W-1:0]    slot_dly_q, slot_dly_d;
  logic                work_sign_q, work_sign_d;
  logic [TEMP_W-1:0]   work_mag_q, work_mag_d;
  logic [DLY_W-1:0]    work_dly_q, work_dly_d;
  logic [11:0]         t_bcd_q, t_bcd_d;
  logic [15:0]         d_bcd_q, d_bcd_d;
  logic [4:0]          idx_q, idx_d;
  logic [7:0]          txdata_q, txdata_d;
  logic                txvalid_q, txvalid_d;
  logic                busy_q, busy_d;
  logic                dropped_q, dropped_d;
  logic                start_q, start_d;

  logic                report, take;
  logic [BCD_WIDTH-1:0] bcd_bin;
  logic [15:0]         bcd_out;
  logic                bcd_done;
  logic [3:0]          tenth;
  logic [7:0]          rec [REC_LEN];
`ifdef TEMPFMT_CHECKSUM_EN
  logic [7:0]          ck;
`endif

  // start_q is high in the first cycle of CONV_T / CONV_D, so the state
  // already selects the right operand when the converter samples it.
  assign bcd_bin = (state_q == CONV_D) ? BCD_WIDTH'(work_dly_q)
                                       : BCD_WIDTH'(work_mag_q[12:4]);

  bin2bcd_seq #(.BCD_WIDTH(BCD_WIDTH)) u_bcd (
    .MCLK   (MCLK),
    .nRESET (nRESET),
    .START  (start_q),
    .BIN    (bcd_bin),
    .BCD    (bcd_out),
    .DONE   (bcd_done)
  );

  always_comb begin
    tenth = 4'(({4'h0, work_mag_q[3:0]} * 8'd10) >> 4);
    for (int unsigned i = 0; i < REC_LEN; i++) rec[i] = CH_SP;
    rec[0]              = CH_T;
    rec[1]              = CH_EQ;
    rec[IDX_SIGN]       = work_sign_q ? CH_MINUS : CH_PLUS;
    rec[IDX_INT]        = dig_ascii(t_bcd_q[11:8]);
    rec[IDX_INT + 1]    = dig_ascii(t_bcd_q[7:4]);
    rec[IDX_INT + 2]    = dig_ascii(t_bcd_q[3:0]);
    rec[IDX_DOT]        = CH_DOT;
    rec[IDX_TENTH]      = dig_ascii(tenth);
    rec[IDX_UNIT]       = CH_C;
    rec[IDX_UNIT + 1]   = CH_SP;
    rec[IDX_UNIT + 2]   = CH_D;
    rec[IDX_UNIT + 3]   = CH_EQ;
    rec[IDX_DLY]        = dig_ascii(d_bcd_q[15:12]);
    rec[IDX_DLY + 1]    = dig_ascii(d_bcd_q[11:8]);
    rec[IDX_DLY + 2]    = dig_ascii(d_bcd_q[7:4]);
    rec[IDX_DLY + 3]    = dig_ascii(d_bcd_q[3:0]);
    rec[IDX_SUFFIX]     = CH_S;
`ifdef TEMPFMT_CHECKSUM_EN
    ck = '0;
    for (int unsigned i = 0; i < BODY_LEN; i++) ck = ck ^ rec[i];
    rec[IDX_TAIL]     = CH_STAR;
    rec[IDX_TAIL + 1] = hex_ascii(ck[7:4]);
    rec[IDX_TAIL + 2] = hex_ascii(ck[3:0]);
`endif
    for (int unsigned j = 0; j < EOL_LEN; j++)
      rec[BODY_LEN + CK_LEN + j] = (EOL_CRLF && j == 0) ? CH_CR : CH_LF;
  end

  always_comb begin
    report = prev_q & ~nFIFOSENDTEMP;
    take   = (state_q == IDLE) && slot_full_q;

    prev_d      = nFIFOSENDTEMP;
    state_d     = state_q;
    slot_full_d = slot_full_q;
    slot_temp_d = slot_temp_q;
    slot_dly_d  = slot_dly_q;
    work_sign_d = work_sign_q;
    work_mag_d  = work_mag_q;
    work_dly_d  = work_dly_q;
    t_bcd_d     = t_bcd_q;
    d_bcd_d     = d_bcd_q;
    idx_d       = idx_q;
    txdata_d    = txdata_q;
    txvalid_d   = txvalid_q;
    busy_d      = busy_q;
    dropped_d   = dropped_q;
    start_d     = 1'b0;

    // A slot being taken this cycle counts as empty for an incoming report.
    if (take) slot_full_d = 1'b0;
    if (report) begin
      if (slot_full_q && !take) begin
        dropped_d = 1'b1;
      end else begin
        slot_full_d = 1'b1;
        slot_temp_d = FIFOTEMP;
        slot_dly_d  = FIFODLYTIME;
      end
    end

    case (state_q)
      IDLE: begin
        if (slot_full_q) begin
          state_d     = CONV_T;
          busy_d      = 1'b1;
          start_d     = 1'b1;
          work_sign_d = slot_temp_q[12];
          work_mag_d  = slot_temp_q[12] ? (~slot_temp_q + 13'd1) : slot_temp_q;
          work_dly_d  = slot_dly_q;
        end
      end
      CONV_T: begin
        if (bcd_done) begin
          t_bcd_d = bcd_out[11:0];
          state_d = CONV_D;
          start_d = 1'b1;
        end
      end
      CONV_D: begin
        if (bcd_done) begin
          d_bcd_d   = bcd_out;
          state_d   = EMIT;
          idx_d     = '0;
          txvalid_d = 1'b1;
          txdata_d  = rec[0];
        end
      end
      EMIT: begin
        if (TXREADY) begin
          if (idx_q == LAST_IDX) begin
            state_d   = IDLE;
            txvalid_d = 1'b0;
            busy_d    = slot_full_d;
          end else begin
            idx_d    = idx_q + 5'd1;
            txdata_d = rec[idx_q + 5'd1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      prev_q      <= 1'b1;
      slot_full_q <= 1'b0;
      slot_temp_q <= '0;
      slot_dly_q  <= '0;
      work_sign_q <= 1'b0;
      work_mag_q  <= '0;
      work_dly_q  <= '0;
      t_bcd_q     <= '0;
      d_bcd_q     <= '0;
      idx_q       <= '0;
      txdata_q    <= '0;
      txvalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      slot_full_q <= slot_full_d;
      slot_temp_q <= slot_temp_d;
      slot_dly_q  <= slot_dly_d;
      work_sign_q <= work_sign_d;
      work_mag_q  <= work_mag_d;
      work_dly_q  <= work_dly_d;
      t_bcd_q     <= t_bcd_d;
      d_bcd_q     <= d_bcd_d;
      idx_q       <= idx_d;
      txdata_q    <= txdata_d;
      txvalid_q   <= txvalid_d;
      busy_q      <= busy_d;
      dropped_q   <= dropped_d;
      start_q     <= start_d;
    end
  end

  assign TXDATA  = txdata_q;
  assign TXVALID = txvalid_q;
  assign BUSY    = busy_q;
  assign DROPPED = dropped_q;

endmodule

// File: tb/tb_tempsense_fifo_formatter.sv
`timescale 1ns/1ps
module tb_tempsense_fifo_formatter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [12:0] temp;
  logic [11:0] dly;
  logic        nsend;
  logic        ready_man, rand_ready, rnd_bit;
  logic        txready;
  assign txready = rand_ready ? rnd_bit : ready_man;

  logic [7:0] txd_a, txd_b;
  logic       txv_a, txv_b, busy_a, busy_b, drop_a, drop_b;

  tempsense_fifo_formatter #(.EOL_CRLF(1'b1)) dut_a (
    .MCLK(clk), .nRESET(rst_n), .FIFOTEMP(temp), .FIFODLYTIME(dly),
    .nFIFOSENDTEMP(nsend), .TXDATA(txd_a), .TXVALID(txv_a), .TXREADY(txready),
    .BUSY(busy_a), .DROPPED(drop_a));

  tempsense_fifo_formatter #(.EOL_CRLF(1'b0)) dut_b (
    .MCLK(clk), .nRESET(rst_n), .FIFOTEMP(temp), .FIFODLYTIME(dly),
    .nFIFOSENDTEMP(nsend), .TXDATA(txd_b), .TXVALID(txv_b), .TXREADY(txready),
    .BUSY(busy_b), .DROPPED(drop_b));

  int n_cmp = 0;
  int n_bad = 0;
  byte unsigned q_a[$];
  byte unsigned q_b[$];
  int unsigned cyc = 0, first_a = 0, last_a = 0;
  int unsigned rule_err = 0;
  logic stall_a = 1'b0, stall_b = 1'b0;
  logic [7:0] held_a, held_b;

  initial rnd_bit = 1'b1;
  always @(negedge clk) rnd_bit = ($urandom_range(3) != 0);

  // Handshake collector plus stream-rule watch (hold while stalled).
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (stall_a && (!txv_a || txd_a != held_a)) rule_err++;
      if (stall_b && (!txv_b || txd_b != held_b)) rule_err++;
      stall_a = txv_a && !txready; held_a = txd_a;
      stall_b = txv_b && !txready; held_b = txd_b;
      if (txv_a && txready) begin
        if (q_a.size() == 0) first_a = cyc;
        last_a = cyc;
        q_a.push_back(txd_a);
      end
      if (txv_b && txready) q_b.push_back(txd_b);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic string with_tail(input string body, input bit crlf);
    string s;
    s = body;
`ifdef TEMPFMT_CHECKSUM_EN
    begin
      byte unsigned x;
      x = 0;
      for (int i = 0; i < body.len(); i++) x ^= body[i];
      s = {s, $sformatf("*%02X", x)};
    end
`endif
    if (crlf) s = {s, "\r\n"};
    else      s = {s, "\n"};
    return s;
  endfunction

  function automatic string model(input logic [12:0] t, input logic [11:0] d, input bit crlf);
    int v, mag;
    v   = t[12] ? int'(t) - 8192 : int'(t);
    mag = (v < 0) ? -v : v;
    return with_tail($sformatf("T=%s%03d.%0dC D=%04ds", t[12] ? "-" : "+",
                               mag / 16, ((mag % 16) * 10) / 16, d), crlf);
  endfunction

  function automatic string show(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "\\r"};
      else if (s[i] == 8'h0A) r = {r, "\\n"};
      else                    r = {r, $sformatf("%c", s[i])};
    end
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_rec(input string name, input bit use_b, input string exp);
    byte unsigned q[$];
    string got;
    bit ok;
    q = use_b ? q_b : q_a;
    got = "";
    foreach (q[i]) got = {got, $sformatf("%c", q[i])};
    ok = (q.size() == exp.len()) && (got == exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got \"%s\" (%0d bytes) want \"%s\" (%0d bytes)",
               name, show(got), q.size(), show(exp), exp.len());
    end
    if (use_b) q_b.delete(); else q_a.delete();
  endtask

  task automatic wait_bytes(input string name, input int la, input int lb);
    int n;
    n = 0;
    while ((q_a.size() < la || q_b.size() < lb) && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 400) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d/%0d bytes want %0d/%0d", name, q_a.size(), q_b.size(), la, lb);
    end
    @(negedge clk);
  endtask

  // Falling edge on nsend, held low 3 cycles; returns cycles from the report edge to TXVALID.
  task automatic apply(input logic [12:0] t, input logic [11:0] d, output int lat);
    int n;
    @(negedge clk);
    temp = t; dly = d; nsend = 1'b0;
    n = 0;
    while (!txv_a && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 3) nsend = 1'b1;
    end
    nsend = 1'b1;
    lat = n - 1;
  endtask

  typedef struct {
    logic [12:0] temp;
    logic [11:0] dly;
    string       body;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input logic [12:0] t, input logic [11:0] d, input string b);
    vec_t v;
    v.temp = t; v.dly = d; v.body = b;
    tbl.push_back(v);
  endtask

  initial begin
    int lat;
    string ea, eb;
    logic [12:0] rt;
    logic [11:0] rd;

    add_vec(13'h01B8, 12'd123,  "T=+027.5C D=0123s");
    add_vec(13'h1F5C, 12'd0,    "T=-010.2C D=0000s");
    add_vec(13'h1FFF, 12'd7,    "T=-000.0C D=0007s");
    add_vec(13'h0960, 12'd4095, "T=+150.0C D=4095s");
    add_vec(13'h1000, 12'd1,    "T=-256.0C D=0001s");
    add_vec(13'h0FFF, 12'd999,  "T=+255.9C D=0999s");
    add_vec(13'h0000, 12'd0,    "T=+000.0C D=0000s");

    rst_n = 1'b0; nsend = 1'b1; temp = '0; dly = '0;
    ready_man = 1'b1; rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txdata",  {24'h0, txd_a}, 32'h0);
    check("rst_txvalid", {31'h0, txv_a}, 32'h0);
    check("rst_busy",    {31'h0, busy_a}, 32'h0);
    check("rst_dropped", {31'h0, drop_a}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_release", {31'h0, txv_a | busy_a | txv_b}, 32'h0);

    // Table vectors, TXREADY tied high.
    foreach (tbl[k]) begin
      apply(tbl[k].temp, tbl[k].dly, lat);
      check($sformatf("latency_ok_v%0d", k), {31'h0, lat <= 31}, 32'h1);
      ea = with_tail(tbl[k].body, 1'b1);
      eb = with_tail(tbl[k].body, 1'b0);
      wait_bytes($sformatf("vec%0d", k), ea.len(), eb.len());
      check($sformatf("contig_v%0d", k), last_a - first_a, ea.len() - 1);
      check_rec($sformatf("rec_crlf_v%0d", k), 1'b0, ea);
      check_rec($sformatf("rec_lf_v%0d", k), 1'b1, eb);
      check($sformatf("busy_done_v%0d", k), {31'h0, busy_a}, 32'h0);
    end
    check("no_drop_yet", {31'h0, drop_a | drop_b}, 32'h0);

    // Back-pressure at byte index 7.
    @(negedge clk);
    temp = 13'h01B8; dly = 12'd123; nsend = 1'b0;
    repeat (2) @(negedge clk);
    nsend = 1'b1;
    for (int n = 0; n < 60 && q_a.size() < 7; n++) @(negedge clk);
    ready_man = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check($sformatf("stall_data_a%0d", s), {24'h0, txd_a}, 32'h35);
      check($sformatf("stall_valid_a%0d", s), {31'h0, txv_a}, 32'h1);
      check($sformatf("stall_data_b%0d", s), {24'h0, txd_b}, 32'h35);
    end
    ready_man = 1'b1;
    ea = model(13'h01B8, 12'd123, 1'b1);
    eb = model(13'h01B8, 12'd123, 1'b0);
    wait_bytes("stall", ea.len(), eb.len());
    check_rec("stall_rec_crlf", 1'b0, ea);
    check_rec("stall_rec_lf", 1'b1, eb);

    // Three reports two cycles apart: third is dropped; held-low level adds nothing.
    @(negedge clk); temp = 13'h0123; dly = 12'd11;  nsend = 1'b0;
    @(negedge clk); nsend = 1'b1;
    @(negedge clk); temp = 13'h1E00; dly = 12'd222; nsend = 1'b0;
    @(negedge clk); nsend = 1'b1;
    @(negedge clk); temp = 13'h0FFF; dly = 12'd999; nsend = 1'b0;
    @(negedge clk);
    check("busy_during_burst", {31'h0, busy_a}, 32'h1);
    ea = {model(13'h0123, 12'd11, 1'b1), model(13'h1E00, 12'd222, 1'b1)};
    eb = {model(13'h0123, 12'd11, 1'b0), model(13'h1E00, 12'd222, 1'b0)};
    wait_bytes("burst", ea.len(), eb.len());
    check_rec("burst_crlf", 1'b0, ea);
    check_rec("burst_lf", 1'b1, eb);
    check("dropped_a", {31'h0, drop_a}, 32'h1);
    check("dropped_b", {31'h0, drop_b}, 32'h1);
    repeat (60) @(negedge clk);
    check("held_low_no_extra", q_a.size() + q_b.size(), 32'h0);
    nsend = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized reports with random back-pressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 15; r++) begin
      rt = 13'($urandom);
      rd = 12'($urandom);
      apply(rt, rd, lat);
      check($sformatf("rand_latency_ok%0d", r), {31'h0, lat <= 31}, 32'h1);
      ea = model(rt, rd, 1'b1);
      eb = model(rt, rd, 1'b0);
      wait_bytes($sformatf("rand%0d", r), ea.len(), eb.len());
      check_rec($sformatf("rand_crlf%0d", r), 1'b0, ea);
      check_rec($sformatf("rand_lf%0d", r), 1'b1, eb);
      repeat ($urandom_range(4)) @(negedge clk);
    end
    rand_ready = 1'b0;
    ready_man = 1'b1;

    // Reset in the middle of a record.
    @(negedge clk);
    temp = 13'h0960; dly = 12'd4095; nsend = 1'b0;
    repeat (2) @(negedge clk);
    nsend = 1'b1;
    for (int n = 0; n < 60 && q_a.size() < 5; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_txvalid", {31'h0, txv_a}, 32'h0);
    check("midrst_busy",    {31'h0, busy_a}, 32'h0);
    check("midrst_dropped", {31'h0, drop_a}, 32'h0);
    check("midrst_txdata",  {24'h0, txd_a}, 32'h0);
    q_a.delete(); q_b.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("no_partial_after_rst", q_a.size() + q_b.size(), 32'h0);

    // Low strobe at reset release counts as one report.
    rst_n = 1'b0;
    temp = 13'h1F5C; dly = 12'd42; nsend = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ea = model(13'h1F5C, 12'd42, 1'b1);
    eb = model(13'h1F5C, 12'd42, 1'b0);
    wait_bytes("rst_low", ea.len(), eb.len());
    repeat (30) @(negedge clk);
    check_rec("rst_low_crlf", 1'b0, ea);
    check_rec("rst_low_lf", 1'b1, eb);
    nsend = 1'b1;
    repeat (2) @(negedge clk);

    check("stream_rules", rule_err, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tempsense_fifo_formatter.md
Name: tempsense_fifo_formatter

Overview:
Downstream consumer of the temperature-sense stage's report strobe. It captures the 13-bit TC77 temperature and the 12-bit computed startup delay on each report, and converts both to decimal with a sequential binary-to-BCD unit. It then emits a fixed ASCII record, one byte at a time, over a valid/ready byte stream to the debug UART TX path.

Parameters:
EOL_CRLF, 1, 1: record ends "\r\n"; 0: record ends "\n" only
BCD_WIDTH, 12, binary width fed to the BCD sub-module; 4 BCD digits out

Ports:
MCLK      in   1   system clock
nRESET    in   1   asynchronous active-low reset
FIFOTEMP  in   13  signed two's-complement temperature, LSB = 0.0625 degC
FIFODLYTIME in 12  unsigned startup delay, seconds
nFIFOSENDTEMP in 1 active-low report; a report is its 1->0 transition, and the low level may persist
TXDATA    out  8   ASCII byte
TXVALID   out  1   TXDATA valid
TXREADY   in   1   sink accepts the byte when TXVALID and TXREADY are both high on a clock edge
BUSY      out  1   a record is being converted or emitted
DROPPED   out  1   sticky: a report was lost; cleared only by reset

Behaviour:
- Reset (async, nRESET=0): TXDATA=8'h00, TXVALID=0, BUSY=0, DROPPED=0, pending slot empty, state IDLE. The edge-detect register resets to 1, so a low input at reset release counts as one report.
- Edge detect: nFIFOSENDTEMP is registered once. A report is prev=1 and cur=0. On a report, FIFOTEMP and FIFODLYTIME are latched into the pending slot in the same cycle.
- Pending slot, depth 1:
  - A report while the slot is full sets DROPPED; the new data is discarded.
  - The slot empties when the FSM moves IDLE->CONV_T.
  - If the slot empties and a report arrives in the same cycle, the report is accepted.
- Temperature arithmetic:
  - sign = FIFOTEMP[12]; mag = sign ? -FIFOTEMP : FIFOTEMP, taken as a 13-bit unsigned value. 13'h1000 gives mag 4096.
  - int = mag[12:4], range 0..256.
  - tenths = (mag[3:0]*10)>>4, truncated, range 0..9.
  - The sign character is '-' whenever sign=1, including when the result reads as zero.
- Record layout, 19 bytes with EOL_CRLF=1 and 18 bytes with EOL_CRLF=0, index 0 first:
  - bytes 0..1: "T="
  - byte 2: sign character
  - bytes 3..5: int, 3 digits with leading zeros
  - byte 6: "."
  - byte 7: tenths digit
  - bytes 8..11: "C D="
  - bytes 12..15: delay, 4 digits with leading zeros
  - byte 16: "s"
  - then "\r\n" (or "\n")
- FSM:
  - IDLE: if the slot is full, set BUSY=1 and go to CONV_T.
  - CONV_T: start BCD on int. On done, latch the digits and go to CONV_D.
  - CONV_D: start BCD on delay. On done, latch the digits and go to EMIT with idx=0.
  - EMIT: drive TXDATA=byte[idx] and TXVALID=1. On handshake, increment idx. On handshake of the last byte, drop TXVALID and go to IDLE; BUSY goes low the same edge unless the slot is full.
- BCD sub-module: one shift per clock; done pulses BCD_WIDTH+1 cycles after start.
- Latency: TXVALID rises for byte 0 no later than 2*(BCD_WIDTH+2)+3 = 31 cycles after the report edge.
- Stream rules:
  - While TXVALID=1 and TXREADY=0, TXDATA is held stable.
  - TXVALID never deasserts without a handshake.
  - With TXREADY tied high, bytes go out one per cycle, back-to-back.

Optional Feature:
- Macro: TEMPFMT_CHECKSUM_EN.
- When defined, "*HH" is inserted before the EOL. HH is the XOR of bytes 0..16, as two uppercase hex ASCII digits. Records are then 22 bytes (CRLF) or 21 bytes (LF only).
- When undefined, no checksum logic is built and the layout is as above.

Decomposition:
- Package tempsense_fmt_pkg holds:
  - state enum {IDLE, CONV_T, CONV_D, EMIT}
  - ASCII constants: 'T', '=', '+', '-', '.', 'C', ' ', 'D', 's', CR, LF, '*'
  - record index constants
  - TEMP_W=13, DLY_W=12
- One sub-module: bin2bcd_seq (double-dabble). Ports: MCLK, nRESET, START, BIN[BCD_WIDTH-1:0], BCD[15:0], DONE.

Test Plan:
- FIFOTEMP=13'h01B8, FIFODLYTIME=123, TXREADY=1 -> "T=+027.5C D=0123s\r\n", 19 contiguous bytes, first byte within 31 cycles.
- FIFOTEMP=13'h1F5C (-10.25), FIFODLYTIME=0 -> "T=-010.2C D=0000s\r\n"; FIFOTEMP=13'h1FFF -> "T=-000.0C ...".
- FIFOTEMP=13'h0960 (150.0), FIFODLYTIME=4095, EOL_CRLF=0 -> "T=+150.0C D=4095s\n", 18 bytes.
- TXREADY low for 5 cycles at idx 7 -> TXDATA holds '5' and TXVALID stays 1; the record completes intact.
- Three reports 2 cycles apart while BUSY:
  - records 1 and 2 are emitted in order; report 3 is dropped and DROPPED=1;
  - holding nFIFOSENDTEMP low produces no extra records.
- nRESET pulsed low mid-EMIT -> TXVALID=0, BUSY=0 and DROPPED=0 immediately, with no partial record after release. With TEMPFMT_CHECKSUM_EN defined, vector 1 ends in "*HH\r\n", where HH is the XOR of bytes 0..16 in uppercase hex.
